// File: rtl/prbs_pkg.sv
// Shared constants and types for the 32-bit PRBS31 additive scrambler link.
// Imported by the descrambler and the keystream step block.
package prbs_pkg;

  localparam int unsigned LFSR_W = 31;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned TAP_HI = 30;
  localparam int unsigned TAP_LO = 27;

  localparam logic [LFSR_W-1:0] SEED_RESET_DEFAULT = 31'h7FFF_FFFF;
  // An all-zero LFSR would lock up, so a zero seed is replaced with this.
  localparam logic [LFSR_W-1:0] SEED_ZERO_SUB = 31'h1;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

endpackage

// File: rtl/prbs31_step32.sv
// Combinational 32-step advance of a Fibonacci PRBS31 LFSR (x^31 + x^28 + 1).
// Produces one keystream word (first step in the MSB) and the advanced state.
module prbs31_step32
  import prbs_pkg::*;
(
  input  logic [LFSR_W-1:0] lfsr,
  output logic [WORD_W-1:0] keystream,
  output logic [LFSR_W-1:0] lfsr_next
);

  logic [LFSR_W-1:0] s;

  always_comb begin
    s         = lfsr;
    keystream = '0;
    for (int k = 0; k < WORD_W; k++) begin
      keystream[WORD_W-1-k] = s[TAP_HI];
      s = {s[LFSR_W-2:0], s[TAP_HI] ^ s[TAP_LO]};
    end
    lfsr_next = s;
  end

endmodule

// File: rtl/prbs31_descrambler_32.sv
// Receive-side PRBS31 descrambler: XORs each accepted 32-bit word with the keystream
// and holds the result in a 1-deep output register with valid/ready on both sides.
module prbs31_descrambler_32
  import prbs_pkg::*;
#(
  parameter int unsigned       CNT_W      = 16,
  parameter logic [LFSR_W-1:0] SEED_RESET = SEED_RESET_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                seed_load,
  input  logic [LFSR_W-1:0]   seed,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORD_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_W-1:0]   out_data,
  output logic [CNT_W-1:0]    word_count,
  output logic                seed_err,
  output logic                running
);

  state_e              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic                out_valid_q, out_valid_d;
  logic [WORD_W-1:0]   out_data_q, out_data_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                seed_err_q, seed_err_d;

  logic [WORD_W-1:0]   keystream;
  logic [LFSR_W-1:0]   lfsr_adv;
  logic                accept;

  prbs31_step32 u_step (
    .lfsr      (lfsr_q),
    .keystream (keystream),
    .lfsr_next (lfsr_adv)
  );

  assign running  = (state_q == StRun);
  // seed_load blocks acceptance so a reseed never mixes with a word in flight.
  assign in_ready = running & ~seed_load & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (seed_load) state_d = StRun;
      StRun:   state_d = StRun;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    lfsr_d      = lfsr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    count_d     = count_q;
    seed_err_d  = seed_err_q;
    if (seed_load) begin
      lfsr_d      = (seed == '0) ? SEED_ZERO_SUB : seed;
      seed_err_d  = (seed == '0);
      count_d     = '0;
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_data_d  = in_data ^ keystream;
      out_valid_d = 1'b1;
      lfsr_d      = lfsr_adv;
      count_d     = count_q + CNT_W'(1);
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      lfsr_q      <= SEED_RESET;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      count_q     <= '0;
      seed_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      count_q     <= count_d;
      seed_err_q  <= seed_err_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign word_count = count_q;
  assign seed_err   = seed_err_q;

endmodule

// File: tb/tb_prbs31_descrambler_32.sv
// Bench for prbs31_descrambler_32: directed steps plus a negedge scoreboard that
// predicts every output word from an independent PRBS31 recurrence model.
module tb_prbs31_descrambler_32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        seed_load;
  logic [30:0] seed;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [15:0] word_count;
  logic        seed_err;
  logic        running;

  int checks = 0;
  int errors = 0;

  logic [31:0] sb[$];
  logic [30:0] m_lfsr;
  logic [15:0] m_count;
  logic        m_serr;
  logic        m_running;

  always #5 clk = ~clk;

  prbs31_descrambler_32 #(
    .CNT_W      (16),
    .SEED_RESET (31'h7FFF_FFFF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seed_load  (seed_load),
    .seed       (seed),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .word_count (word_count),
    .seed_err   (seed_err),
    .running    (running)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Output sequence o[n]: o[0..30] = seed[30..0], o[n+31] = o[n] ^ o[n+3].
  task automatic model_word(input logic [30:0] s, output logic [31:0] ks,
                            output logic [30:0] ns);
    logic b [0:62];
    for (int i = 0; i < 31; i++) b[i] = s[30-i];
    for (int n = 0; n < 32; n++) b[n+31] = b[n] ^ b[n+3];
    for (int k = 0; k < 32; k++) ks[31-k] = b[k];
    for (int i = 0; i < 31; i++) ns[30-i] = b[32+i];
  endtask

  always @(negedge clk) begin
    logic [31:0] ks;
    logic [30:0] ns;
    logic        exp_ready;
    if (!rst_n) begin
      sb.delete();
      m_lfsr    = 31'h7FFF_FFFF;
      m_count   = '0;
      m_serr    = 1'b0;
      m_running = 1'b0;
    end else begin
      exp_ready = m_running & ~seed_load & ((sb.size() == 0) | out_ready);
      chk("out_valid", {31'b0, out_valid}, {31'b0, sb.size() != 0});
      chk("running", {31'b0, running}, {31'b0, m_running});
      chk("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
      chk("word_count", {16'b0, word_count}, {16'b0, m_count});
      chk("seed_err", {31'b0, seed_err}, {31'b0, m_serr});
      if (out_valid && out_ready && sb.size() != 0) chk("out_data", out_data, sb.pop_front());
      if (seed_load) begin
        sb.delete();
        m_lfsr    = (seed == 31'h0) ? 31'h1 : seed;
        m_serr    = (seed == 31'h0);
        m_count   = '0;
        m_running = 1'b1;
      end else if (in_valid && exp_ready) begin
        model_word(m_lfsr, ks, ns);
        sb.push_back(in_data ^ ks);
        m_lfsr  = ns;
        m_count = m_count + 16'd1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [30:0] s);
    seed_load = 1'b1;
    seed      = s;
    step();
    seed_load = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    seed_load = 1'b0;
    seed      = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    step();
    step();
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst out_data", out_data, 32'd0);
    chk("rst running", {31'b0, running}, 32'd0);
    chk("rst in_ready", {31'b0, in_ready}, 32'd0);
    rst_n = 1'b1;
    step();
    // IDLE ignores input
    in_valid = 1'b1;
    step();
    chk("idle no accept", {16'b0, word_count}, 32'd0);
    in_valid = 1'b0;

    // Known-answer words
    load(31'h7FFF_FFFF);
    in_valid = 1'b1;
    in_data  = 32'h0000_0000;
    step();
    in_valid = 1'b0;
    chk("kat0 out_data", out_data, 32'hFFFF_FFFE);
    chk("kat0 count", {16'b0, word_count}, 32'd1);

    load(31'h7FFF_FFFF);
    in_valid = 1'b1;
    in_data  = 32'hFFFF_FFFF;
    step();
    in_valid = 1'b0;
    chk("kat1 out_data", out_data, 32'h0000_0001);

    load(31'h0);
    chk("zero seed_err", {31'b0, seed_err}, 32'd1);
    in_valid = 1'b1;
    in_data  = 32'h0;
    step();
    in_valid = 1'b0;
    chk("zero seed out_data", out_data, 32'h0000_0002);
    load(31'd5);
    chk("seed_err cleared", {31'b0, seed_err}, 32'd0);

    // Backpressure: word held, LFSR frozen, then full throughput
    load(31'h7FFF_FFFF);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h0;
    step();
    for (int i = 0; i < 10; i++) begin
      chk("stall in_ready", {31'b0, in_ready}, 32'd0);
      chk("stall out_data", out_data, 32'hFFFF_FFFE);
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("drain count", {16'b0, word_count}, 32'(i + 2));
    end
    in_valid = 1'b0;
    step();

    // Seed load collides with in_valid
    seed_load = 1'b1;
    seed      = 31'h7FFF_FFFF;
    in_valid  = 1'b1;
    in_data   = 32'h0;
    #1;
    chk("collide in_ready", {31'b0, in_ready}, 32'd0);
    step();
    seed_load = 1'b0;
    chk("collide count", {16'b0, word_count}, 32'd0);
    step();
    in_valid = 1'b0;
    chk("post collide out_data", out_data, 32'hFFFF_FFFE);
    chk("post collide count", {16'b0, word_count}, 32'd1);

    // Random backpressure
    load(31'h1234_567);
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      step();
    end

    // Long stream through the counter wrap
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    load(31'h2ACE_1357);
    in_valid = 1'b1;
    for (int i = 0; i < 65536 + 3; i++) begin
      in_data = $urandom;
      step();
    end
    chk("wrap count", {16'b0, word_count}, 32'd3);

    // Asynchronous reset mid-stream
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("async rst running", {31'b0, running}, 32'd0);
    chk("async rst count", {16'b0, word_count}, 32'd0);
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prbs31_descrambler_32.md
Name: prbs31_descrambler_32

Overview:
- Receive-side end of the team's 32-bit additive scrambler link.
- Each accepted 32-bit scrambled word is XORed with 32 bits of PRBS31 keystream, which recovers the plaintext word.
- Sits between the link receive word stream and the vALU datapath.
- Valid/ready handshake on both sides, a 1-deep output register, seed loading, and a word counter.

Parameters:
- CNT_W, 16, width of word_count; the counter wraps at 2^CNT_W.
- SEED_RESET, 31'h7FFF_FFFF, LFSR value after reset.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- seed_load  input  1  single-cycle pulse; loads seed and (re)starts the block
- seed  input  31  LFSR seed, sampled when seed_load=1
- in_valid  input  1  scrambled word available
- in_ready  output  1  block accepts a word this cycle
- in_data  input  32  scrambled word
- out_valid  output  1  descrambled word available
- out_ready  input  1  consumer accepts a word this cycle
- out_data  output  32  descrambled word
- word_count  output  CNT_W  words accepted since the last seed load
- seed_err  output  1  sticky flag: a zero seed was substituted
- running  output  1  block is in RUN

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, lfsr=SEED_RESET.
  - out_valid=0, out_data=0, word_count=0, seed_err=0, running=0, in_ready=0.
- States:
  - IDLE: seed_load -> RUN. Input is not accepted in IDLE (in_ready=0).
  - RUN: remains in RUN. A further seed_load reseeds the block and it stays in RUN.
  - There is no exit to IDLE except reset.
- Seed load:
  - lfsr <= (seed==0) ? 31'h1 : seed.
  - seed_err <= (seed==0). It holds until the next seed_load.
  - word_count <= 0.
  - out_valid <= 0, which discards any pending output word.
- LFSR step (Fibonacci PRBS31, x^31+x^28+1):
  - Output bit is s[30].
  - Next state is s <= {s[29:0], s[30]^s[27]}.
- Keystream word: 32 successive steps. The step-k output (k=0..31) maps to keystream bit 31-k.
- Handshake:
  - in_ready = running & ~seed_load & (~out_valid | out_ready).
  - Accept when in_valid & in_ready.
- On accept:
  - out_data <= in_data ^ keystream.
  - out_valid <= 1.
  - lfsr advances 32 steps.
  - word_count increments, wrapping at 2^CNT_W.
  - Latency is 1 cycle from accept to out_valid.
- Output:
  - out_valid & out_ready with no new accept -> out_valid <= 0.
  - Accept and drain in the same cycle -> out_valid stays 1 and out_data takes the new word (full throughput).
- Hold rules:
  - out_data and out_valid are stable while out_valid & ~out_ready.
  - The LFSR does not advance without an accept.
- Simultaneous seed_load and in_valid: the seed wins, no word is accepted, and in_ready=0 that cycle.
- Reset mid-stream: everything returns to reset values immediately, and pending output is lost.

Decomposition:
- Shared package `prbs_pkg`:
  - LFSR_W=31, TAP_HI=30, TAP_LO=27.
  - Reset seed constant.
  - Zero-seed substitute value 31'h1.
- Sub-module `prbs31_step32` (combinational):
  - Input: lfsr state.
  - Outputs: 32-bit keystream and the lfsr state after 32 steps.
  - The future transmit-side scrambler reuses it.

Test Plan:
- Reset, then seed_load with seed=31'h7FFF_FFFF, then in_data=32'h0000_0000 -> one cycle later out_valid=1 and out_data=32'hFFFF_FFFE; word_count=1.
- Same seed, in_data=32'hFFFF_FFFF -> out_data=32'h0000_0001.
- seed_load with seed=0 -> seed_err=1. Then in_data=0 -> out_data=32'h0000_0002 (substituted seed 1). A following seed_load with seed=5 clears seed_err.
- out_ready held 0 with in_valid held 1:
  - First word is accepted, then in_ready=0.
  - out_data is stable for 10 cycles and the LFSR is frozen.
  - Raising out_ready gives one word per cycle thereafter.
- seed_load asserted in the same cycle as in_valid -> no accept and word_count=0. The next cycle accepts the word using the new seed's first keystream word.
- Streaming and wrap:
  - Stream 2^CNT_W+3 words against a reference model -> all outputs match and word_count=3.
  - Assert rst_n=0 mid-stream -> out_valid=0 and running=0 asynchronously.
